patch_sum_accum: RTL and testbench
==================================

# patch_sum_accum

Accumulates a 5x5 pixel patch arriving one pixel per cycle in raster order and produces its five row sums and five column sums. It sits directly upstream of `mean_calc`: outputs `r1..r5` and `c1..c5` connect straight to its 16-bit sum inputs. Results are held under a valid/ready handshake so the downstream pipeline can stall without losing a patch.

## Interface
- `pixelBitWidth`, 12: width of incoming pixels. Must be ≤ 13 so that a 5-term sum fits in 16 bits.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `pix_in` input pixelBitWidth: pixel sample.
- `pix_valid` input 1: `pix_in` is valid this cycle.
- `pix_sop` input 1: start-of-patch marker, qualified by `pix_valid`.
- `pix_ready` output 1: the block accepts a pixel this cycle.
- `r1..r5` output 16 each: sums of patch rows 0..4.
- `c1..c5` output 16 each: sums of patch columns 0..4.
- `out_valid` output 1: sums are valid and held.
- `out_ready` input 1: the downstream stage takes the sums.
- `resync` output 1: one-cycle pulse when a partial patch is discarded because of `pix_sop`.

## Operation
- Accept event: `pix_valid & pix_ready`.
- Counters:
  - `col_cnt` 0..4 and `row_cnt` 0..4, in raster order with `col_cnt` fastest.
  - Pixel (row r, col c) is the accept with `row_cnt`=r and `col_cnt`=c.
- Two-state FSM:
  - ACCUM:
    - `pix_ready`=1.
    - On each accept, zero-extend the pixel to 16 bits and add it to row accumulator [row_cnt] and column accumulator [col_cnt].
    - Then advance the counters.
    - On the accept of pixel (4,4), move to HOLD.
  - HOLD:
    - `pix_ready`=0 and `out_valid`=1.
    - Accumulators are frozen and drive `r*`/`c*`.
    - On `out_ready`, clear all accumulators and counters and return to ACCUM.
- `pix_sop` handling:
  - Accept with `pix_sop`=1 while the counters are at (0,0): normal first pixel.
  - Accept with `pix_sop`=1 while the counters are not (0,0):
    - Discard the partial patch.
    - Accumulators are loaded with this pixel as pixel (0,0), so row0 = col0 = pixel and all others = 0.
    - Counters go to (0,1).
    - `resync` pulses the following cycle.
  - `pix_sop` is not required. A patch may start without it.
- `pix_sop` is ignored in HOLD, because no accept can occur there.
- Arithmetic:
  - Unsigned throughout.
  - Maximum row or column sum is 5·(2^pixelBitWidth−1) = 20475 at 12 bits. No saturation logic is needed.
- Reset, from any state including mid-patch or HOLD:
  - State goes to ACCUM; counters and accumulators go to 0.
  - `out_valid`=0, `resync`=0, `pix_ready`=1 in the cycle after `rst` deasserts.
  - All `r*`/`c*` outputs read 0.

## Timing
- `r*`/`c*` are driven directly from the accumulator registers and are stable for the whole time `out_valid` is high.
- `out_valid` rises the cycle after the 25th accept.
- `pix_ready` is a pure function of state (registered) and is never combinationally dependent on `pix_valid` or `out_ready`.
- Handshake completes in the cycle where `out_valid & out_ready`. In the next cycle `out_valid`=0 and `pix_ready`=1.
- Throughput: 25 accept cycles plus at least 1 HOLD cycle gives a minimum of 26 cycles per patch.
- `out_ready` asserted while `out_valid`=0 has no effect.
- `pix_valid` while `pix_ready`=0 is ignored; upstream must hold the pixel.

## Configuration
- `PATCH_SUM_TOTAL_EN` defined:
  - Adds output `patch_sum` [16:0], the sum of all 25 pixels, accumulated alongside the row and column sums.
  - Resets and clears with them, and is valid under `out_valid`.
  - `pix_sop` resync loads it with the pixel.
- Not defined: no `patch_sum` port and no extra register.

## Test plan
- Reset, then pixels 1..25 in raster order, `out_ready`=1 → `r1..r5`=15,40,65,90,115; `c1..c5`=55,60,65,70,75; `out_valid` for exactly one cycle; `patch_sum`=325 with `PATCH_SUM_TOTAL_EN`.
- All 25 pixels = 4095 → every `r*`/`c*` = 20475; `patch_sum`=102375.
- Patch completes with `out_ready`=0 for 10 cycles → `out_valid` held, sums unchanged, `pix_ready`=0 throughout, `pix_valid` ignored; the next patch of all-1 pixels gives all sums = 5.
- Send 7 pixels of value 9, then a `pix_sop` pixel of value 3, then 24 pixels of value 1 → `resync` pulses once; `r1`=7, `c1`=7, other sums = 5.
- `rst` asserted after 12 pixels (and separately during HOLD) → all outputs 0, `pix_ready`=1; the next 1..25 patch gives the first scenario's values.
- Random `pix_valid` gaps (~50%) over 3 back-to-back patches → sums match the reference model and no pixel is lost or duplicated.

Source files
------------

// File: rtl/patch_sum_accum.sv
// 5x5 patch row/column sum accumulator with a valid/ready hold stage for mean_calc.
// Optional macro PATCH_SUM_TOTAL_EN adds a 17-bit whole-patch sum output.
module patch_sum_accum #(
    parameter int pixelBitWidth = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [pixelBitWidth-1:0] pix_in,
    input  logic                     pix_valid,
    input  logic                     pix_sop,
    output logic                     pix_ready,
    output logic [15:0]              r1,
    output logic [15:0]              r2,
    output logic [15:0]              r3,
    output logic [15:0]              r4,
    output logic [15:0]              r5,
    output logic [15:0]              c1,
    output logic [15:0]              c2,
    output logic [15:0]              c3,
    output logic [15:0]              c4,
    output logic [15:0]              c5,
    output logic                     out_valid,
    input  logic                     out_ready,
`ifdef PATCH_SUM_TOTAL_EN
    output logic [16:0]              patch_sum,
`endif
    output logic                     resync
);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] row_acc [5];
    logic [15:0] col_acc [5];
    logic [2:0]  row_cnt;
    logic [2:0]  col_cnt;
    logic [15:0] pix_ext;
    logic        accept;
    logic        last;
    logic        restart;
`ifdef PATCH_SUM_TOTAL_EN
    logic [16:0] total_acc;
`endif

    assign pix_ext = 16'(pix_in);
    assign accept  = pix_valid & (state == ACCUM);
    assign last    = (row_cnt == 3'd4) && (col_cnt == 3'd4);
    // A start marker away from (0,0) abandons the partial patch.
    assign restart = accept & pix_sop & ((row_cnt != 3'd0) || (col_cnt != 3'd0));

    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pix_ready = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM: begin
                pix_ready = 1'b1;
                if (accept && last && !restart) state_nxt = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || (state == HOLD && out_ready)) begin
            for (int i = 0; i < 5; i++) begin
                row_acc[i] <= 16'd0;
                col_acc[i] <= 16'd0;
            end
            row_cnt <= 3'd0;
            col_cnt <= 3'd0;
        end else if (restart) begin
            for (int i = 0; i < 5; i++) begin
                row_acc[i] <= (i == 0) ? pix_ext : 16'd0;
                col_acc[i] <= (i == 0) ? pix_ext : 16'd0;
            end
            row_cnt <= 3'd0;
            col_cnt <= 3'd1;
        end else if (accept) begin
            for (int i = 0; i < 5; i++) begin
                if (row_cnt == 3'(i)) row_acc[i] <= row_acc[i] + pix_ext;
                if (col_cnt == 3'(i)) col_acc[i] <= col_acc[i] + pix_ext;
            end
            if (col_cnt == 3'd4) begin
                col_cnt <= 3'd0;
                row_cnt <= (row_cnt == 3'd4) ? 3'd0 : row_cnt + 3'd1;
            end else begin
                col_cnt <= col_cnt + 3'd1;
            end
        end
    end

`ifdef PATCH_SUM_TOTAL_EN
    always_ff @(posedge clk) begin
        if (rst || (state == HOLD && out_ready)) total_acc <= 17'd0;
        else if (restart)                        total_acc <= 17'(pix_in);
        else if (accept)                         total_acc <= total_acc + 17'(pix_in);
    end

    assign patch_sum = total_acc;
`endif

    always_ff @(posedge clk) begin
        if (rst) resync <= 1'b0;
        else     resync <= restart;
    end

    assign r1 = row_acc[0];
    assign r2 = row_acc[1];
    assign r3 = row_acc[2];
    assign r4 = row_acc[3];
    assign r5 = row_acc[4];
    assign c1 = col_acc[0];
    assign c2 = col_acc[1];
    assign c3 = col_acc[2];
    assign c4 = col_acc[3];
    assign c5 = col_acc[4];

endmodule

// File: tb/tb_patch_sum_accum.sv
// Self-checking bench for patch_sum_accum: table-driven patches, corner sequences, random model check.
module tb_patch_sum_accum;
    localparam int PW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] pix_in = '0;
    logic          pix_valid = 1'b0;
    logic          pix_sop = 1'b0;
    logic          out_ready = 1'b0;
    logic          pix_ready, out_valid, resync;
    logic [15:0]   r1, r2, r3, r4, r5, c1, c2, c3, c4, c5;
`ifdef PATCH_SUM_TOTAL_EN
    logic [16:0]   patch_sum;
`endif

    patch_sum_accum #(.pixelBitWidth(PW)) dut (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_sop(pix_sop),
        .pix_ready(pix_ready),
        .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5),
        .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef PATCH_SUM_TOTAL_EN
        .patch_sum(patch_sum),
`endif
        .resync(resync)
    );

    always #5 clk = ~clk;

    logic [15:0] rs [5];
    logic [15:0] cs [5];
    assign rs[0] = r1; assign rs[1] = r2; assign rs[2] = r3; assign rs[3] = r4; assign rs[4] = r5;
    assign cs[0] = c1; assign cs[1] = c2; assign cs[2] = c3; assign cs[3] = c4; assign cs[4] = c5;

    typedef struct {
        int kind;   // 0: ramp 1..25, 1: constant val
        int val;
        int stall;
        bit rdy;
        bit sop;
        int er [5];
        int ec [5];
        int et;
    } vec_t;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  n_resync = 0;
    int  px [25];
    int  er [5];
    int  ec [5];
    int  et;
    bit  idle_rdy = 1'b0;
    vec_t tbl [4];

    always @(negedge clk) if (resync) n_resync++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic compute_model();
        for (int i = 0; i < 5; i++) begin
            er[i] = 0;
            ec[i] = 0;
        end
        et = 0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                er[r] += px[r*5+c];
                ec[c] += px[r*5+c];
                et    += px[r*5+c];
            end
    endtask

    task automatic check_sums(input string tag);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("%s_r%0d", tag, i+1), rs[i], er[i]);
            chk($sformatf("%s_c%0d", tag, i+1), cs[i], ec[i]);
        end
`ifdef PATCH_SUM_TOTAL_EN
        chk($sformatf("%s_total", tag), patch_sum, et);
`endif
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("%s_r%0d", tag, i+1), rs[i], 0);
            chk($sformatf("%s_c%0d", tag, i+1), cs[i], 0);
        end
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_pix_ready"}, pix_ready, 1);
        chk({tag, "_resync"}, resync, 0);
`ifdef PATCH_SUM_TOTAL_EN
        chk({tag, "_total"}, patch_sum, 0);
`endif
    endtask

    // Inputs change on the falling edge; one call = exactly one accept.
    task automatic send_pixel(input int v, input bit sop, input bit gaps);
        int n = 0;
        if (gaps) repeat ($urandom_range(0, 1)) @(negedge clk);
        while (!pix_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!pix_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL pix_ready_wait: got 0 expected 1");
        end
        pix_valid = 1'b1;
        pix_in    = PW'(v);
        pix_sop   = sop;
        @(negedge clk);
        pix_valid = 1'b0;
        pix_sop   = 1'b0;
    endtask

    task automatic check_out(input string tag, input int stall);
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_pix_ready_hold"}, pix_ready, 0);
        check_sums(tag);
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            pix_valid = 1'b1;
            pix_in    = PW'($urandom_range(0, 4095));
            pix_sop   = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk({tag, "_stall_out_valid"}, out_valid, 1);
            chk({tag, "_stall_pix_ready"}, pix_ready, 0);
            check_sums({tag, "_stall"});
        end
        pix_valid = 1'b0;
        pix_sop   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_release_out_valid"}, out_valid, 0);
        chk({tag, "_release_pix_ready"}, pix_ready, 1);
        out_ready = idle_rdy;
    endtask

    task automatic run_patch(input string tag, input bit gaps, input bit sop, input int stall);
        for (int k = 0; k < 25; k++) send_pixel(px[k], sop && (k == 0), gaps);
        check_out(tag, stall);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_ramp();
        for (int k = 0; k < 25; k++) px[k] = k + 1;
        er = '{15, 40, 65, 90, 115};
        ec = '{55, 60, 65, 70, 75};
        et = 325;
    endtask

    initial begin
        tbl[0].kind = 0; tbl[0].val = 0; tbl[0].stall = 0; tbl[0].rdy = 1; tbl[0].sop = 1;
        tbl[0].er = '{15, 40, 65, 90, 115}; tbl[0].ec = '{55, 60, 65, 70, 75}; tbl[0].et = 325;
        tbl[1].kind = 1; tbl[1].val = 4095; tbl[1].stall = 0; tbl[1].rdy = 1; tbl[1].sop = 0;
        tbl[1].er = '{20475, 20475, 20475, 20475, 20475};
        tbl[1].ec = '{20475, 20475, 20475, 20475, 20475}; tbl[1].et = 102375;
        tbl[2].kind = 0; tbl[2].val = 0; tbl[2].stall = 10; tbl[2].rdy = 0; tbl[2].sop = 1;
        tbl[2].er = '{15, 40, 65, 90, 115}; tbl[2].ec = '{55, 60, 65, 70, 75}; tbl[2].et = 325;
        tbl[3].kind = 1; tbl[3].val = 1; tbl[3].stall = 0; tbl[3].rdy = 0; tbl[3].sop = 0;
        tbl[3].er = '{5, 5, 5, 5, 5}; tbl[3].ec = '{5, 5, 5, 5, 5}; tbl[3].et = 25;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_zero("reset");

        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 25; k++) px[k] = (tbl[t].kind == 0) ? k + 1 : tbl[t].val;
            er = tbl[t].er;
            ec = tbl[t].ec;
            et = tbl[t].et;
            idle_rdy  = tbl[t].rdy;
            out_ready = idle_rdy;
            run_patch($sformatf("vec%0d", t), 1'b0, tbl[t].sop, tbl[t].stall);
        end
        idle_rdy  = 1'b0;
        out_ready = 1'b0;

        // Partial patch of 9s abandoned by a start marker carrying 3.
        begin
            int n0 = n_resync;
            for (int k = 0; k < 7; k++) send_pixel(9, k == 0, 1'b0);
            send_pixel(3, 1'b1, 1'b0);
            for (int k = 0; k < 24; k++) send_pixel(1, 1'b0, 1'b0);
            er = '{7, 5, 5, 5, 5};
            ec = '{7, 5, 5, 5, 5};
            et = 27;
            check_out("resync", 0);
            chk("resync_pulses", n_resync - n0, 1);
        end

        // Reset in the middle of a patch.
        for (int k = 0; k < 12; k++) send_pixel(k + 1, 1'b0, 1'b0);
        do_reset();
        check_zero("rst_mid");
        load_ramp();
        run_patch("after_rst_mid", 1'b0, 1'b0, 0);

        // Reset while results are held.
        load_ramp();
        for (int k = 0; k < 25; k++) send_pixel(px[k], 1'b0, 1'b0);
        @(negedge clk);
        chk("hold_before_rst_out_valid", out_valid, 1);
        do_reset();
        check_zero("rst_hold");
        load_ramp();
        run_patch("after_rst_hold", 1'b0, 1'b1, 0);

        // Back-to-back random patches with input gaps.
        idle_rdy  = 1'b1;
        out_ready = 1'b1;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 25; k++) px[k] = $urandom_range(0, 4095);
            compute_model();
            run_patch($sformatf("rand%0d", p), 1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
